tg68k_fpu_response_encoder: RTL and testbench
=============================================

# tg68k_fpu_response_encoder

Coprocessor-side response generator for the TG68K FPU. It accepts a decoded FPU command from the CPU interface and sequences the 16-bit response primitives the CPU reads back from the response CIR: operand-transfer request, busy, done, or take-exception. It tracks each command from acceptance to completion through a small state machine, and pulses `exec_start` to the FPU execution unit.

## Interface
- `TIMEOUT_CYCLES`, default 1024: busy-watchdog limit in clocks. Used only with `TG68K_FPU_RESP_TIMEOUT_EN`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: decoded command present.
- `cmd_ready` out 1: block is idle and can accept a command.
- `cmd_illegal` in 1: command was decoded illegal or unsupported.
- `cmd_ea_xfer` in 1: command moves an operand through an effective address.
- `cmd_dir` in 1: transfer direction. 0 = memory to FPU (load); 1 = FPU to memory (store).
- `cmd_format` in 3: operand format code 000–110.
- `cmd_abort` in 1: CPU abort/restore; forces return to IDLE.
- `xfer_done` in 1: CPU has finished the requested operand transfer.
- `fpu_done` in 1: execution unit has finished.
- `fpu_exception` in 1: qualifies `fpu_done`; the operation faulted.
- `fpu_exc_vector` in 8: vector number reported with `fpu_exception`.
- `exec_start` out 1: one-cycle start pulse to the execution unit.
- `resp_word` out 16: current response primitive.
- `resp_valid` out 1: `resp_word` is meaningful.
- `resp_read` in 1: CPU reads the response CIR this cycle.

## Operation
- Primitive encodings:
  - NULL/DONE = 16'h0802.
  - BUSY = 16'h8900.
  - EXC = {8'h1C, vector}.
  - XFER = 16'h9000 | (`cmd_dir` << 13) | len.
- len by `cmd_format`: 000→4, 001→4, 010→12, 011→12, 100→2, 101→8, 110→1.
- States: IDLE, XFER, XWAIT, EXEC, DONE, EXC.
- A command is latched when `cmd_valid & cmd_ready`. The latch holds dir, len and a "transfer pending" flag.
- Routing from IDLE:
  - `cmd_illegal`, or `cmd_ea_xfer` with format 111 → EXC, vector 8'd11.
  - `cmd_ea_xfer` and dir=0 → XFER.
  - otherwise → EXEC.
- IDLE: `cmd_ready`=1, `resp_valid`=0, `resp_word`=NULL.
- XFER: `resp_valid`=1, `resp_word`=XFER. On `resp_read` → XWAIT.
- XWAIT: `resp_valid`=0. Waits for `xfer_done`:
  - on a load → EXEC;
  - on a store → DONE.
- EXEC:
  - `resp_valid`=1, `resp_word`=BUSY. `resp_read` does not change state.
  - `exec_start`=1 in the first EXEC cycle only.
  - On `fpu_done`: if `fpu_exception` → EXC with `fpu_exc_vector`; else if a store transfer is pending → XFER; else → DONE.
- DONE: `resp_valid`=1, NULL. On `resp_read` → IDLE.
- EXC: `resp_valid`=1, EXC word. On `resp_read` → IDLE.
- `cmd_abort` in any state → IDLE next cycle. It has priority over every other event. `exec_start` is not asserted on that cycle.
- `cmd_valid` outside IDLE is ignored; no queueing.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `resp_valid`=0, `resp_word`=16'h0802, `exec_start`=0. All are registered or decoded from registered state.
- Accept at edge N: the first primitive (XFER or EXC) is visible after edge N. For a command with no transfer, EXEC and `exec_start` are visible after edge N.
- `fpu_done` is honoured in every EXEC cycle, including the one carrying `exec_start`.
- `fpu_done` and `resp_read` in the same EXEC cycle: the transition wins; the read consumes BUSY.
- `xfer_done` outside XWAIT is ignored.
- Minimum command with no transfer: 3 cycles (accept, EXEC with `fpu_done`, DONE read).

## Configuration
- `TG68K_FPU_RESP_TIMEOUT_EN` defined:
  - a counter clears on EXEC entry and increments each EXEC cycle;
  - when it reaches `TIMEOUT_CYCLES` without `fpu_done`, next state is EXC with vector 8'd13 (protocol violation).
- Undefined: no counter. EXEC waits for `fpu_done` indefinitely.

## Test plan
- Reset, then a load command (`cmd_ea_xfer`=1, dir=0, format 101) → `resp_word`=16'h9008. `resp_read` → XWAIT; `xfer_done` → `exec_start` pulse and BUSY 16'h8900; `fpu_done` → 16'h0802; `resp_read` → `cmd_ready`=1.
- Store command (dir=1, format 010) → BUSY first; `fpu_done` → 16'hB00C; `resp_read`, then `xfer_done` → 16'h0802.
- `cmd_illegal`=1 → 16'h1C0B next cycle with no `exec_start`. A format-111 transfer command gives the same result.
- EXEC with `fpu_done`=1, `fpu_exception`=1, vector 8'h34 → 16'h1C34; `resp_read` → IDLE.
- `cmd_abort` asserted in XWAIT and in EXEC → IDLE next cycle, `resp_valid`=0, `cmd_ready`=1. Assert `nReset`=0 mid-EXEC → immediate reset values.
- With the macro and `TIMEOUT_CYCLES`=8, EXEC without `fpu_done` → 16'h1C0D after 8 EXEC cycles. Without the macro, BUSY holds for 100+ cycles.

Source files
------------

// File: rtl/tg68k_fpu_response_encoder.sv
// TG68K FPU coprocessor response sequencer: command -> response CIR primitives.
// Optional busy watchdog enabled by defining TG68K_FPU_RESP_TIMEOUT_EN.
module tg68k_fpu_response_encoder #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_illegal,
    input  logic        cmd_ea_xfer,
    input  logic        cmd_dir,
    input  logic [2:0]  cmd_format,
    input  logic        cmd_abort,
    input  logic        xfer_done,
    input  logic        fpu_done,
    input  logic        fpu_exception,
    input  logic [7:0]  fpu_exc_vector,
    output logic        exec_start,
    output logic [15:0] resp_word,
    output logic        resp_valid,
    input  logic        resp_read
);

    localparam logic [15:0] W_NULL      = 16'h0802;
    localparam logic [15:0] W_BUSY      = 16'h8900;
    localparam logic [7:0]  VEC_ILLEGAL = 8'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_XWAIT,
        S_EXEC,
        S_DONE,
        S_EXC
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [3:0]  len_q, len_d;
    logic        pend_q, pend_d;
    logic [7:0]  vec_q, vec_d;
    logic        start_q, start_d;
    logic        to_hit;

    function automatic logic [3:0] fmt_len(input logic [2:0] f);
        case (f)
            3'b000, 3'b001: fmt_len = 4'd4;
            3'b010, 3'b011: fmt_len = 4'd12;
            3'b100:         fmt_len = 4'd2;
            3'b101:         fmt_len = 4'd8;
            3'b110:         fmt_len = 4'd1;
            default:        fmt_len = 4'd0;
        endcase
    endfunction

`ifdef TG68K_FPU_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] VEC_PROTO = 8'd13;

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts EXEC cycles already spent, including the current one.
    always_comb begin
        cnt_d  = '0;
        to_hit = 1'b0;
        if (state_q == S_EXEC) begin
            cnt_d  = cnt_q + CW'(1);
            to_hit = (cnt_d == CW'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign to_hit         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        pend_d  = pend_q;
        vec_d   = vec_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d  = cmd_dir;
                    len_d  = fmt_len(cmd_format);
                    pend_d = cmd_ea_xfer & cmd_dir;
                    if (cmd_illegal ||
                        (cmd_ea_xfer && cmd_format == 3'b111)) begin
                        state_d = S_EXC;
                        vec_d   = VEC_ILLEGAL;
                        pend_d  = 1'b0;
                    end else if (cmd_ea_xfer && !cmd_dir) begin
                        state_d = S_XFER;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_XFER: if (resp_read) state_d = S_XWAIT;
            S_XWAIT: begin
                if (xfer_done) begin
                    state_d = dir_q ? S_DONE : S_EXEC;
                    pend_d  = 1'b0;
                end
            end
            S_EXEC: begin
                if (fpu_done) begin
                    if (fpu_exception) begin
                        state_d = S_EXC;
                        vec_d   = fpu_exc_vector;
                    end else if (pend_q) begin
                        state_d = S_XFER;
                    end else begin
                        state_d = S_DONE;
                    end
`ifdef TG68K_FPU_RESP_TIMEOUT_EN
                end else if (to_hit) begin
                    state_d = S_EXC;
                    vec_d   = VEC_PROTO;
`endif
                end
            end
            S_DONE, S_EXC: if (resp_read) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cmd_abort) state_d = S_IDLE;
        // Abort is applied above, so a killed command never starts.
        start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            len_q   <= 4'd0;
            pend_q  <= 1'b0;
            vec_q   <= 8'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            start_q <= start_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign exec_start = start_q;
    assign resp_valid = (state_q == S_XFER) || (state_q == S_EXEC) ||
                        (state_q == S_DONE) || (state_q == S_EXC);

    always_comb begin
        resp_word = W_NULL;
        case (state_q)
            S_XFER:  resp_word = {1'b1, 1'b0, dir_q, 1'b1, 8'h00, len_q};
            S_EXEC:  resp_word = W_BUSY;
            S_EXC:   resp_word = {8'h1C, vec_q};
            default: resp_word = W_NULL;
        endcase
    end

endmodule

// File: tb/tb_tg68k_fpu_response_encoder.sv
// Scoreboard bench for tg68k_fpu_response_encoder; builds with or without
// TG68K_FPU_RESP_TIMEOUT_EN (DUT instantiated with TIMEOUT_CYCLES = 8).
module tb_tg68k_fpu_response_encoder;

    logic        clk = 1'b0;
    logic        nReset;
    logic        cmd_valid, cmd_ready, cmd_illegal, cmd_ea_xfer, cmd_dir;
    logic [2:0]  cmd_format;
    logic        cmd_abort, xfer_done, fpu_done, fpu_exception;
    logic [7:0]  fpu_exc_vector;
    logic        exec_start, resp_valid, resp_read;
    logic [15:0] resp_word;

    int n_chk  = 0;
    int n_fail = 0;
    int start_tok = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    tg68k_fpu_response_encoder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .nReset(nReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_illegal(cmd_illegal), .cmd_ea_xfer(cmd_ea_xfer),
        .cmd_dir(cmd_dir), .cmd_format(cmd_format),
        .cmd_abort(cmd_abort), .xfer_done(xfer_done),
        .fpu_done(fpu_done), .fpu_exception(fpu_exception),
        .fpu_exc_vector(fpu_exc_vector), .exec_start(exec_start),
        .resp_word(resp_word), .resp_valid(resp_valid),
        .resp_read(resp_read)
    );

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: every CPU read of a valid primitive and every start pulse
    // is matched against what the stimulus predicted.
    always @(negedge clk) begin
        if (nReset === 1'b1) begin
            if (resp_valid && resp_read) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_read: got %h expected none",
                             resp_word);
                end else begin
                    chk(name_q.pop_front(), resp_word, exp_q.pop_front());
                end
            end
            if (exec_start) begin
                if (start_tok == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_start: got 1 expected 0");
                end else begin
                    start_tok--;
                    chk("start_with_busy", resp_word, 16'h8900);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        cmd_valid = 0; cmd_illegal = 0; cmd_ea_xfer = 0; cmd_dir = 0;
        cmd_format = 3'd0; cmd_abort = 0; xfer_done = 0; fpu_done = 0;
        fpu_exception = 0; fpu_exc_vector = 8'd0; resp_read = 0;
    endtask

    task automatic issue(input logic ill, input logic ea, input logic dir,
                         input logic [2:0] fmt);
        cmd_valid = 1; cmd_illegal = ill; cmd_ea_xfer = ea;
        cmd_dir = dir; cmd_format = fmt;
        cyc();
        cmd_valid = 0; cmd_illegal = 0; cmd_ea_xfer = 0;
        cmd_dir = 0; cmd_format = 3'd0;
    endtask

    task automatic rd(input string nm, input logic [15:0] w);
        exp_q.push_back(w);
        name_q.push_back(nm);
        resp_read = 1;
        cyc();
        resp_read = 0;
    endtask

    task automatic pulse_xfer();
        xfer_done = 1; cyc(); xfer_done = 0;
    endtask

    task automatic pulse_done();
        fpu_done = 1; cyc(); fpu_done = 0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, {15'd0, cmd_ready}, 16'd1);
        chk({nm, "_valid"}, {15'd0, resp_valid}, 16'd0);
        chk({nm, "_word"}, resp_word, 16'h0802);
        chk({nm, "_start"}, {15'd0, exec_start}, 16'd0);
    endtask

    initial begin
        clear_in();
        nReset = 1;
        #2 nReset = 0;
        #1 chk_idle("reset");
        cyc(); cyc();
        nReset = 1;
        cyc();

        // Load, format 101: XFER 9008 -> XWAIT -> EXEC -> DONE
        issue(0, 1, 0, 3'b101);
        chk("load_xfer_valid", {15'd0, resp_valid}, 16'd1);
        pulse_xfer();
        rd("load_xfer", 16'h9008);
        chk("xwait_valid", {15'd0, resp_valid}, 16'd0);
        chk("xwait_ready", {15'd0, cmd_ready}, 16'd0);
        start_tok++;
        pulse_xfer();
        rd("load_busy", 16'h8900);
        chk("start_one_cycle", {15'd0, exec_start}, 16'd0);
        pulse_done();
        rd("load_done", 16'h0802);
        chk_idle("load_end");

        // Store, format 010: BUSY -> XFER B00C -> XWAIT -> DONE
        start_tok++;
        issue(0, 1, 1, 3'b010);
        cmd_valid = 1; cmd_illegal = 1;
        rd("store_busy", 16'h8900);
        cmd_valid = 0; cmd_illegal = 0;
        pulse_done();
        rd("store_xfer", 16'hB00C);
        pulse_xfer();
        rd("store_done", 16'h0802);
        chk_idle("store_end");

        // Illegal command and format-111 transfer
        issue(1, 0, 0, 3'b000);
        chk("ill_no_start", {15'd0, exec_start}, 16'd0);
        rd("illegal_exc", 16'h1C0B);
        issue(0, 1, 0, 3'b111);
        rd("fmt7_exc", 16'h1C0B);
        chk_idle("ill_end");

        // Minimum 3-cycle command
        start_tok++;
        issue(0, 0, 0, 3'b000);
        pulse_done();
        rd("min_done", 16'h0802);

        // Exception on the start cycle, read consuming BUSY
        start_tok++;
        issue(0, 0, 0, 3'b000);
        fpu_done = 1; fpu_exception = 1; fpu_exc_vector = 8'h34;
        rd("exc_busy", 16'h8900);
        fpu_done = 0; fpu_exception = 0; fpu_exc_vector = 8'd0;
        rd("fpu_exc", 16'h1C34);
        chk_idle("exc_end");

        // Abort in XWAIT, in EXEC, and on the accept cycle
        issue(0, 1, 0, 3'b110);
        rd("abort_xfer", 16'h9001);
        cmd_abort = 1; cyc(); cmd_abort = 0;
        chk_idle("abort_xwait");
        start_tok++;
        issue(0, 0, 0, 3'b000);
        cmd_abort = 1; fpu_done = 1; cyc(); cmd_abort = 0; fpu_done = 0;
        chk_idle("abort_exec");
        cmd_abort = 1;
        issue(0, 0, 0, 3'b000);
        cmd_abort = 0;
        chk_idle("abort_accept");

`ifdef TG68K_FPU_RESP_TIMEOUT_EN
        start_tok++;
        issue(0, 0, 0, 3'b000);
        repeat (7) cyc();
        chk("to_busy_c8", resp_word, 16'h8900);
        cyc();
        rd("timeout_exc", 16'h1C0D);
        chk_idle("to_end");
`else
        start_tok++;
        issue(0, 0, 0, 3'b000);
        repeat (120) cyc();
        chk("busy_hold", resp_word, 16'h8900);
        pulse_done();
        rd("hold_done", 16'h0802);
`endif

        // Reset in the middle of EXEC
        start_tok++;
        issue(0, 0, 0, 3'b000);
        cyc();
        nReset = 0;
        #1 chk_idle("mid_reset");
        cyc();
        nReset = 1;
        cyc();

        chk("missed_start", 16'(start_tok), 16'd0);
        chk("unread_resp", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
